// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, decode_stage and ALU/branch.
// Latency: none (wires only).
// Backpressure: carries in_valid/in_ready upstream and out_valid/out_ready downstream.
// Ports: in_valid/in_ready/in_instr, flush, out_valid/out_ready, decoded
//        fields (op1, op2, aluop, imm, shift, illegal) and illegal_cnt.
interface decode_stage_if #(
  parameter int IW   = 16,
  parameter int RW   = 3,
  parameter int IMMW = 8,
  parameter int CNTW = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   in_instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_op1;
  logic [RW-1:0]   out_op2;
  logic [4:0]      out_aluop;
  logic [IMMW-1:0] out_imm;
  logic            out_shift;
  logic            out_illegal;
  logic [CNTW-1:0] illegal_cnt;

  // Environment side: fetch upstream plus the consuming unit downstream.
  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_aluop, out_imm,
           out_shift, out_illegal, illegal_cnt
  );

  // Decode stage side.
  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_aluop, out_imm,
           out_shift, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction decode with illegal-opcode flag and saturating illegal counter.
// Latency: 1 cycle (word accepted at edge N is presented from edge N).
// Backpressure: 2-entry main+skid buffer, in_ready registered; flush empties both entries.
// Ports: clk, rst_n (async active-low), io (decode_stage_if.slave) carrying the
//        upstream word handshake, flush, downstream decoded-entry handshake and illegal_cnt.
module decode_stage #(
  parameter int IW   = 16,
  parameter int RW   = 3,
  parameter int IMMW = 8,
  parameter int CNTW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave io
);

  localparam int OPW = IW - 1 - 2*RW;     // register-format opcode width
  localparam int SW  = IW - 1 - RW - IMMW; // immediate-format sub-op width

  typedef struct packed {
    logic            illegal;
    logic            shift;
    logic [4:0]      aluop;
    logic [RW-1:0]   op1;
    logic [RW-1:0]   op2;
    logic [IMMW-1:0] imm;
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state_q, state_d;
  dec_t            main_q, main_d;
  dec_t            skid_q, skid_d;
  dec_t            dec;
  logic            in_ready_q;
  logic [CNTW-1:0] cnt_q;
  logic            accept;

  logic [OPW-1:0]  opc;
  logic [SW-1:0]   sub;
  logic [31:0]     opc_w;
  logic [31:0]     sub_w;

  assign opc   = io.in_instr[IW-2:2*RW];
  assign sub   = io.in_instr[IW-2:RW+IMMW];
  assign opc_w = 32'(opc);
  assign sub_w = 32'(sub);

  // Combinational decode of the word currently on in_instr.
  // Register opcodes 7 and 17 are holes in the map, so each legal range
  // is shifted down by the number of holes below it.
  always_comb begin
    dec = '0;
    if (!io.in_instr[IW-1]) begin
      dec.illegal = 1'b0;
      if (opc_w <= 32'd6) begin
        dec.aluop = opc_w[4:0];
      end else if (opc_w >= 32'd8 && opc_w <= 32'd16) begin
        dec.aluop = 5'(opc_w - 32'd1);
      end else if (opc_w >= 32'd18 && opc_w <= 32'd20) begin
        dec.aluop = 5'(opc_w - 32'd2);
      end else begin
        dec.illegal = 1'b1;
      end
      if (!dec.illegal) begin
        dec.op1 = io.in_instr[2*RW-1:RW];
        dec.op2 = io.in_instr[RW-1:0];
      end
    end else begin
      if (sub_w <= 32'd11) begin
        dec.aluop = 5'(sub_w + 32'd19);
        dec.op1   = io.in_instr[RW+IMMW-1:IMMW];
        dec.imm   = io.in_instr[IMMW-1:0];
      end else begin
        dec.illegal = 1'b1;
      end
    end
    // Illegal words leave every field at zero, so shift is only set for legal ones.
    dec.shift = !dec.illegal && (dec.aluop >= 5'd8) && (dec.aluop <= 5'd13);
  end

  assign accept = io.in_valid & in_ready_q;

  // Next-state and buffer steering. Flush wins over every other event.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (io.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = dec;
          end
        end
        ONE: begin
          if (accept && io.out_ready) begin
            main_d = dec;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = dec;
          end else if (io.out_ready) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so nothing new can arrive this cycle.
          if (io.out_ready) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      // Ready is a flop: it drops only once both entries are occupied.
      in_ready_q <= (state_d != TWO);
      if (accept && !io.flush && dec.illegal && (cnt_q != {CNTW{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign io.in_ready    = in_ready_q;
  assign io.out_valid   = (state_q != EMPTY);
  assign io.out_op1     = main_q.op1;
  assign io.out_op2     = main_q.op2;
  assign io.out_aluop   = main_q.aluop;
  assign io.out_imm     = main_q.imm;
  assign io.out_shift   = main_q.shift;
  assign io.out_illegal = main_q.illegal;
  assign io.illegal_cnt = cnt_q;

endmodule
